fault_flag_gen: RTL and testbench
=================================

# fault_flag_gen

Upstream conditioning stage for the power-stage fault detector. Accepts a time-multiplexed stream of unsigned ADC samples (bus voltage, temperature, current), compares each against programmable thresholds with hysteresis, and filters with consecutive-sample counters. Produces the 4-bit `fault_flags` vector consumed directly by the detector FSM, plus per-channel staleness indicators.

## Interface

- `DATA_W`, 12: sample and threshold width (unsigned).
- `FILT_N`, 3: consecutive qualifying samples needed to toggle a filtered flag (1..15).
- `HYST`, 16: hysteresis band in LSBs.
- `STALE_CYC`, 1000: clock cycles without a sample on a channel before its stale bit sets.
- `clk` input 1: single clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `sample_valid` input 1: sample present.
- `sample_ready` output 1: block can accept a sample.
- `sample_ch` input 2: 0 = bus voltage, 1 = temperature, 2 = current, 3 = reserved.
- `sample_data` input DATA_W: ADC code.
- `uv_thr`, `ov_thr`, `ot_thr`, `oc_thr` input DATA_W each: quasi-static trip thresholds.
- `fault_flags` output 4: bit0 undervoltage, bit1 overtemp, bit2 overvoltage, bit3 overcurrent.
- `stale` output 3: per-channel no-sample indicator (bit index = channel).
- `bad_ch` output 1: one-cycle pulse when a channel-3 sample is accepted.

## Operation

- Accept on `sample_valid && sample_ready`. `sample_ready` is a register: 0 in reset, 1 from the first edge after `reset_n` deasserts, and 1 thereafter. There is no backpressure.
- Mapping: ch0 drives undervoltage and overvoltage, ch1 drives overtemp, ch2 drives overcurrent. A ch3 sample is discarded, pulses `bad_ch`, and changes no state.
- Trip/clear conditions, evaluated against the current flag value:
  - OV, OT, OC trip when `data > thr`. They clear when `data < thr - HYST`. The subtraction saturates at 0, so a flag with `thr < HYST` never clears.
  - UV trips when `data < uv_thr`. It clears when `data > uv_thr + HYST`. The addition saturates at 2^DATA_W-1.
  - All arithmetic uses DATA_W+1 bits with no wrap.
- Filter, per condition:
  - A 4-bit counter increments on each sample from its channel that meets the toggle condition for the current flag state. A sample from that channel that does not meet it resets the counter to 0.
  - When the counter reaches FILT_N, the flag toggles and the counter clears.
  - Samples from other channels leave the counter untouched.
- Overcurrent fast path: the OC flag sets on the first tripping sample (filter bypassed for set). Clearing OC still requires FILT_N consecutive clear samples.
- Staleness:
  - Each channel has a counter that clears on an accepted sample of that channel and otherwise increments, saturating.
  - `stale[ch]` is 1 while the counter is >= STALE_CYC.
  - While stale, that channel's flags hold their value.
- Threshold change: new values apply from the next sample's compare stage. Flags never change without a sample.

## Timing

- Stage 1, on the accept edge: register channel, data, and all four compare results.
- Stage 2, on the next edge: update filter counters and `fault_flags`.
- A deciding sample accepted at edge N is visible on `fault_flags` after edge N+1. Back-to-back samples sustain one sample per cycle.
- `bad_ch` is asserted in the cycle after the accept edge.
- `stale` updates one cycle after its counter crosses the threshold and clears one cycle after the accepting edge.
- Reset values: `fault_flags` = 0, `stale` = 0, `bad_ch` = 0, `sample_ready` = 0. All counters and pipeline registers are 0.
- Reset mid-operation immediately clears all outputs and discards in-flight stage-1 data.

## Structure

- Package `fault_pkg` holds:
  - flag bit indices (UV=0, OT=1, OV=2, OC=3);
  - the channel enum `adc_ch_t` (VBUS, TEMP, IBUS, RSVD);
  - default FILT_N, HYST and STALE_CYC.
- Sub-module `fault_cond_filter` is instantiated four times. It holds the counter plus flag and is parameterised by FILT_N and a `fast_set` bit (1 only for OC). Its inputs are `hit_set`, `hit_clr` and `ch_match`.
- The top level holds the handshake, compare stage, saturating hysteresis math and stale counters.

## Test plan

All scenarios use DATA_W=12, FILT_N=3, HYST=16, STALE_CYC=1000, `ov_thr`=3000, `uv_thr`=1000.

- OV with interleaving: ch0 samples 3001, 3001, then a ch1 sample, then ch0 3001 -> `fault_flags[2]` goes 1 one cycle after the third ch0 accept. It stays 1 for a following ch0 sample of 2990 (inside hysteresis).
- OV clear: from OV set, three ch0 samples of 2983 -> flag clears. A sequence 2983, 2990, 2983 does not clear it.
- UV: three ch0 samples of 999 -> bit0 = 1. Three ch0 samples of 1017 -> bit0 = 0. Three samples of 1010 leave it at 1.
- OC fast path: `oc_thr`=2000, one ch2 sample of 2001 -> bit3 = 1 after edge N+1. Two samples of 1983 then 2001 leave it at 1.
- Stale and bad channel: no ch1 samples for 1000 cycles -> `stale[1]` = 1. A ch1 sample clears it. A ch3 sample pulses `bad_ch` once and leaves flags unchanged.
- Reset mid-run: with bit3 set, assert `reset_n`=0 -> `fault_flags`=0 and `sample_ready`=0 immediately. After release, `sample_ready`=1 after one edge.

Source files
------------

// File: rtl/fault_pkg.sv
// fault_pkg: shared flag indices, ADC channel encoding and default tuning for fault_flag_gen.
package fault_pkg;
  localparam int FLAG_UV = 0;
  localparam int FLAG_OT = 1;
  localparam int FLAG_OV = 2;
  localparam int FLAG_OC = 3;
  localparam int FILT_N_DEF = 3;
  localparam int HYST_DEF = 16;
  localparam int STALE_CYC_DEF = 1000;
  typedef enum logic [1:0] {VBUS, TEMP, IBUS, RSVD} adc_ch_t;
endpackage

// File: rtl/fault_flag_gen_if.sv
// fault_flag_gen_if: ADC sample stream into the fault conditioning stage.
interface fault_flag_gen_if #(parameter int DATA_W = 12) ();
  logic              sample_valid;
  logic              sample_ready;
  logic [1:0]        sample_ch;
  logic [DATA_W-1:0] sample_data;
  modport master(output sample_valid, sample_ch, sample_data, input sample_ready);
  modport slave(input sample_valid, sample_ch, sample_data, output sample_ready);
endinterface

// File: rtl/fault_cond_filter.sv
// fault_cond_filter: consecutive-sample filter toggling one fault flag, with optional immediate set.
module fault_cond_filter #(
  parameter int FILT_N   = 3,
  parameter bit fast_set = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ch_match,
  input  logic hit_set,
  input  logic hit_clr,
  output logic flag
);
  logic [3:0] cnt;
  logic       hit;
  logic       fast;
  always_comb begin
    hit  = flag ? hit_clr : hit_set;
    fast = fast_set && !flag && hit_set;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (ch_match) begin
      if (fast) begin
        flag <= 1'b1;
        cnt  <= '0;
      end else if (!hit) begin
        cnt <= '0;
      end else if (cnt == 4'(FILT_N - 1)) begin
        flag <= !flag;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/fault_flag_gen.sv
// fault_flag_gen: threshold compare with hysteresis, per-condition filtering and staleness for ADC samples.
module fault_flag_gen
  import fault_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int FILT_N    = FILT_N_DEF,
  parameter int HYST      = HYST_DEF,
  parameter int STALE_CYC = STALE_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  fault_flag_gen_if.slave   s,
  input  logic [DATA_W-1:0] uv_thr,
  input  logic [DATA_W-1:0] ov_thr,
  input  logic [DATA_W-1:0] ot_thr,
  input  logic [DATA_W-1:0] oc_thr,
  output logic [3:0]        fault_flags,
  output logic [2:0]        stale,
  output logic              bad_ch
);
  localparam logic [DATA_W:0] HYST_W = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0] MAX_W  = {1'b0, {DATA_W{1'b1}}};
  localparam int              SW     = $clog2(STALE_CYC + 1);
  localparam logic [SW-1:0]   SMAX   = SW'(STALE_CYC);
  function automatic logic [DATA_W:0] lo(input logic [DATA_W-1:0] t);
    return ({1'b0, t} < HYST_W) ? '0 : {1'b0, t} - HYST_W;
  endfunction
  function automatic logic [DATA_W:0] hi(input logic [DATA_W-1:0] t);
    return ({1'b0, t} + HYST_W > MAX_W) ? MAX_W : {1'b0, t} + HYST_W;
  endfunction
  adc_ch_t         ch_in;
  adc_ch_t         s1_ch;
  logic            acc;
  logic            s1_vld;
  logic [DATA_W:0] d;
  logic [3:0]      set_c, clr_c, set_q, clr_q, m;
  logic [SW-1:0]   scnt [3];
  always_comb begin
    ch_in          = adc_ch_t'(s.sample_ch);
    acc            = s.sample_valid && s.sample_ready;
    d              = {1'b0, s.sample_data};
    set_c          = '0;
    clr_c          = '0;
    set_c[FLAG_UV] = d < {1'b0, uv_thr};
    clr_c[FLAG_UV] = d > hi(uv_thr);
    set_c[FLAG_OV] = d > {1'b0, ov_thr};
    clr_c[FLAG_OV] = d < lo(ov_thr);
    set_c[FLAG_OT] = d > {1'b0, ot_thr};
    clr_c[FLAG_OT] = d < lo(ot_thr);
    set_c[FLAG_OC] = d > {1'b0, oc_thr};
    clr_c[FLAG_OC] = d < lo(oc_thr);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s.sample_ready <= 1'b0;
      s1_vld         <= 1'b0;
      s1_ch          <= VBUS;
      set_q          <= '0;
      clr_q          <= '0;
      bad_ch         <= 1'b0;
    end else begin
      s.sample_ready <= 1'b1;
      s1_vld         <= acc && ch_in != RSVD;
      bad_ch         <= acc && ch_in == RSVD;
      s1_ch          <= ch_in;
      set_q          <= set_c;
      clr_q          <= clr_c;
    end
  end
  // counters saturate at the threshold; stale is the registered compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) scnt[i] <= '0;
      stale <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        scnt[i]  <= (acc && s.sample_ch == 2'(i)) ? '0 : (scnt[i] == SMAX ? scnt[i] : scnt[i] + 1'b1);
        stale[i] <= scnt[i] >= SMAX;
      end
    end
  end
  always_comb begin
    m          = '0;
    m[FLAG_UV] = s1_vld && s1_ch == VBUS && !stale[0];
    m[FLAG_OV] = s1_vld && s1_ch == VBUS && !stale[0];
    m[FLAG_OT] = s1_vld && s1_ch == TEMP && !stale[1];
    m[FLAG_OC] = s1_vld && s1_ch == IBUS && !stale[2];
  end
  for (genvar g = 0; g < 4; g++) begin : f
    fault_cond_filter #(.FILT_N(FILT_N), .fast_set(g == FLAG_OC)) u (
      .clk     (clk),
      .reset_n (reset_n),
      .ch_match(m[g]),
      .hit_set (set_q[g]),
      .hit_clr (clr_q[g]),
      .flag    (fault_flags[g])
    );
  end
endmodule

// File: tb/tb_fault_flag_gen.sv
// tb_fault_flag_gen: directed samples with a scoreboard of expected flags and bad_ch pulses.
module tb_fault_flag_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] uv_thr, ov_thr, ot_thr, oc_thr;
  logic [3:0]  fault_flags;
  logic [2:0]  stale;
  logic        bad_ch;
  logic        p1, p2;
  logic [3:0]  qf[$];
  logic        qb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  fault_flag_gen_if #(.DATA_W(12)) bus ();
  fault_flag_gen dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .s          (bus),
    .uv_thr     (uv_thr),
    .ov_thr     (ov_thr),
    .ot_thr     (ot_thr),
    .oc_thr     (oc_thr),
    .fault_flags(fault_flags),
    .stale      (stale),
    .bad_ch     (bad_ch)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= bus.sample_valid && bus.sample_ready;
      p2 <= p1;
    end
  end
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  task automatic send(input logic [1:0] c, input int d, input logic [3:0] f, input logic b);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_ch    = c;
    bus.sample_data  = 12'(d);
    qf.push_back(f);
    qb.push_back(b);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic monitor();
    logic eb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        eb = 1'b0;
        if (p1) begin
          if (qb.size() == 0) chk("bad_ch_queue_empty", 1, 0);
          else eb = qb.pop_front();
        end
        chk("bad_ch", int'(bad_ch), int'(eb));
        if (p2) begin
          if (qf.size() == 0) chk("flags_queue_empty", 1, 0);
          else chk("fault_flags", int'(fault_flags), int'(qf.pop_front()));
        end
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_ch = 2'd0;
    bus.sample_data = '0;
    uv_thr = 12'd1000;
    ov_thr = 12'd3000;
    ot_thr = 12'd2500;
    oc_thr = 12'd2000;
    fork
      monitor();
      begin
        repeat (2) @(negedge clk);
        chk("rst_flags", int'(fault_flags), 0);
        chk("rst_stale", int'(stale), 0);
        chk("rst_bad_ch", int'(bad_ch), 0);
        chk("rst_ready", int'(bus.sample_ready), 0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", int'(bus.sample_ready), 0);
        @(posedge clk);
        #1 chk("ready_after_edge", int'(bus.sample_ready), 1);
        // OV with an interleaved ch1 sample, then hold inside hysteresis
        send(0, 3001, 4'b0000, 0);
        send(0, 3001, 4'b0000, 0);
        send(1, 100, 4'b0000, 0);
        send(0, 3001, 4'b0100, 0);
        send(0, 2990, 4'b0100, 0);
        send(0, 2983, 4'b0100, 0);
        send(0, 2990, 4'b0100, 0);
        send(0, 2983, 4'b0100, 0);
        send(0, 2983, 4'b0100, 0);
        send(0, 2983, 4'b0000, 0);
        idle(2);
        // UV set, hold within band, clear above band
        send(0, 999, 4'b0000, 0);
        send(0, 999, 4'b0000, 0);
        send(0, 999, 4'b0001, 0);
        send(0, 1010, 4'b0001, 0);
        send(0, 1010, 4'b0001, 0);
        send(0, 1010, 4'b0001, 0);
        send(0, 1017, 4'b0001, 0);
        send(0, 1017, 4'b0001, 0);
        send(0, 1017, 4'b0000, 0);
        idle(2);
        // OC fast set, interrupted clear, full clear, set again
        send(2, 2001, 4'b1000, 0);
        send(2, 1983, 4'b1000, 0);
        send(2, 1983, 4'b1000, 0);
        send(2, 2001, 4'b1000, 0);
        send(2, 1983, 4'b1000, 0);
        send(2, 1983, 4'b1000, 0);
        send(2, 1983, 4'b0000, 0);
        send(2, 2001, 4'b1000, 0);
        send(1, 2501, 4'b1000, 0);
        send(1, 2501, 4'b1000, 0);
        send(1, 2501, 4'b1010, 0);
        send(1, 100, 4'b1010, 0);
        idle(0);
        repeat (1000) @(posedge clk);
        #1 chk("stale1_before", int'(stale[1]), 0);
        @(posedge clk);
        #1 chk("stale1_set", int'(stale[1]), 1);
        send(1, 100, 4'b1010, 0);
        idle(0);
        @(posedge clk);
        #1 chk("stale1_cleared", int'(stale[1]), 0);
        send(3, 4095, 4'b1010, 1);
        idle(4);
        chk("queue_drained_pre_reset", qf.size() + qb.size(), 0);
        #2 rst_n = 1'b0;
        #1 chk("midrst_flags", int'(fault_flags), 0);
        chk("midrst_ready", int'(bus.sample_ready), 0);
        chk("midrst_stale", int'(stale), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_ready_before_edge", int'(bus.sample_ready), 0);
        @(posedge clk);
        #1 chk("rel_ready_after_edge", int'(bus.sample_ready), 1);
        send(0, 3001, 4'b0000, 0);
        idle(4);
        chk("queue_drained_end", qf.size() + qb.size(), 0);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
